lock_access_ctrl: RTL and testbench

Sequencer and arbiter that shares one serial combination-lock FSM between N_REQ requesters. It grants one requester at a time in round-robin order, clears the lock, and shifts the requester's code word into the lock's `x` input one bit per cycle. It then samples the lock's `unlocked` output and reports pass/fail to the granted requester. Consecutive failures are counted; reaching MAX_FAIL forces a timed lockout during which no requests are served.

---
 rtl/lock_ctrl_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/lock_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lock_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: shared state encoding and default sizing for the lock
// access controller and the combination-lock FSM it drives.
//   STATE_W / state_t   : controller FSM state encoding
//   DEF_CODE_W          : default code length in bits
//   DEF_MAX_FAIL        : default consecutive failures before lockout
//   DEF_LOCKOUT_CYC     : default lockout duration in clock cycles
package lock_ctrl_pkg;

   localparam int unsigned STATE_W         = 3;
   localparam int unsigned DEF_CODE_W      = 4;
   localparam int unsigned DEF_MAX_FAIL    = 3;
   localparam int unsigned DEF_LOCKOUT_CYC = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_CHECK   = 3'd3,
      ST_REPORT  = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Returns the first set request
// bit at or after ptr, wrapping around.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   onehot : one-hot winner (all zero when no request)
//   idx    : winner index
//   valid  : at least one request present
module rr_arbiter #(
   parameter int unsigned N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         onehot,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     valid
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   // Scan N_REQ positions starting at ptr; first hit wins.
   always_comb begin
      int unsigned pos;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      pos    = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= N_REQ) pos = pos - N_REQ;
         if (!valid && req[ID_W'(pos)]) begin
            valid               = 1'b1;
            onehot[ID_W'(pos)]  = 1'b1;
            idx                 = ID_W'(pos);
         end
      end
   end

endmodule

// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl: shares one serial combination-lock FSM between N_REQ
// requesters. Grants round-robin, clears the lock, shifts the winner's code
// MSB first, samples the lock result and reports it. MAX_FAIL consecutive
// failures force a LOCKOUT_CYC-cycle lockout.
//   clk, rst      : clock, asynchronous active-high reset
//   req, code_in  : per-requester level request and code word
//   grant         : one-cycle one-hot grant pulse
//   lock_clr      : one-cycle clear pulse to the lock
//   lock_x        : serial code bit to the lock
//   lock_unlocked : lock Moore output
//   busy          : controller not idle
//   done, pass    : result strobe and result (pass held until next done)
//   done_id       : requester index of the last result
//   locked_out    : lockout in progress
//   fail_cnt      : consecutive failure count (global)
module lock_access_ctrl
   import lock_ctrl_pkg::*;
#(
   parameter int unsigned CODE_W      = DEF_CODE_W,
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned MAX_FAIL    = DEF_MAX_FAIL,
   parameter int unsigned LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*CODE_W-1:0]       code_in,
   output logic [N_REQ-1:0]              grant,
   output logic                          lock_clr,
   output logic                          lock_x,
   input  logic                          lock_unlocked,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [$clog2(N_REQ)-1:0]      done_id,
   output logic                          locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

   localparam int unsigned ID_W   = $clog2(N_REQ);
   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int unsigned IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int unsigned LO_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     cur_id;
   logic [CODE_W-1:0]   code_sr;
   logic [IDX_W-1:0]    idx;
   logic [LO_W-1:0]     lo_cnt;

   logic [N_REQ-1:0]    win_onehot;
   logic [ID_W-1:0]     win_idx;
   logic                win_valid;
   logic [CODE_W-1:0]   sel_code;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (win_onehot),
      .idx    (win_idx),
      .valid  (win_valid)
   );

   // Code word of the current arbitration winner.
   always_comb begin
      sel_code = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_idx == ID_W'(i)) sel_code = code_in[i*CODE_W +: CODE_W];
      end
   end

   // Session FSM. Outputs are registered for the state being entered, so
   // each output is valid during the cycle its state occupies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         cur_id     <= '0;
         code_sr    <= '0;
         idx        <= '0;
         lo_cnt     <= '0;
         grant      <= '0;
         lock_clr   <= 1'b0;
         lock_x     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         done_id    <= '0;
         locked_out <= 1'b0;
         fail_cnt   <= '0;
      end else begin
         grant    <= '0;
         lock_clr <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  cur_id   <= win_idx;
                  code_sr  <= sel_code;
                  rr_ptr   <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                  grant    <= win_onehot;
                  lock_clr <= 1'b1;
                  lock_x   <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               lock_x  <= code_sr[CODE_W-1];
               code_sr <= code_sr << 1;
               idx     <= '0;
               state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (idx == IDX_W'(CODE_W - 1)) begin
                  lock_x <= 1'b0;
                  state  <= ST_CHECK;
               end else begin
                  lock_x  <= code_sr[CODE_W-1];
                  code_sr <= code_sr << 1;
                  idx     <= idx + 1'b1;
               end
            end
            ST_CHECK: begin
               // Lock has registered the last bit by now.
               pass    <= lock_unlocked;
               done    <= 1'b1;
               done_id <= cur_id;
               if (lock_unlocked) begin
                  fail_cnt <= '0;
               end else if (fail_cnt != FAIL_W'(MAX_FAIL)) begin
                  fail_cnt <= fail_cnt + 1'b1;
               end
               state <= ST_REPORT;
            end
            ST_REPORT: begin
               if (fail_cnt == FAIL_W'(MAX_FAIL)) begin
                  locked_out <= 1'b1;
                  lo_cnt     <= LO_W'(LOCKOUT_CYC - 1);
                  state      <= ST_LOCKOUT;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            ST_LOCKOUT: begin
               if (lo_cnt == '0) begin
                  fail_cnt   <= '0;
                  locked_out <= 1'b0;
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  lo_cnt <= lo_cnt - 1'b1;
               end
            end
            default: begin
               busy       <= 1'b0;
               locked_out <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lock_access_ctrl.sv
// tb_lock_access_ctrl: scoreboard bench for lock_access_ctrl with a behavioural
// 4-bit serial lock whose secret is 4'b1011.
module tb_lock_access_ctrl;

   localparam logic [3:0] SECRET = 4'b1011;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [7:0]  code_in;
   logic [1:0]  grant;
   logic        lock_clr;
   logic        lock_x;
   logic        lock_unlocked;
   logic        busy;
   logic        done;
   logic        pass;
   logic [0:0]  done_id;
   logic        locked_out;
   logic [1:0]  fail_cnt;

   lock_access_ctrl #(
      .CODE_W(4), .N_REQ(2), .MAX_FAIL(3), .LOCKOUT_CYC(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .code_in       (code_in),
      .grant         (grant),
      .lock_clr      (lock_clr),
      .lock_x        (lock_x),
      .lock_unlocked (lock_unlocked),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .done_id       (done_id),
      .locked_out    (locked_out),
      .fail_cnt      (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serial lock: last four bits since clear, Moore compare.
   logic [3:0] hist;
   always @(posedge clk or posedge rst) begin
      if (rst)           hist <= 4'b0;
      else if (lock_clr) hist <= 4'b0;
      else               hist <= {hist[2:0], lock_x};
   end
   assign lock_unlocked = (hist == SECRET);

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   typedef struct {
      int id;
      bit ok;
      int fcnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   exp_ptr  = 0;
   int   exp_fail = 0;

   // Result monitor: every done pops one expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("done_id",  32'(done_id),  32'(mon_e.id));
            chk("pass",     32'(pass),     32'(mon_e.ok));
            chk("fail_cnt", 32'(fail_cnt), 32'(mon_e.fcnt));
         end
      end
   end

   function automatic int predict(input logic [1:0] r);
      for (int i = 0; i < 2; i++) begin
         int j;
         j = (exp_ptr + i) % 2;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   // Wait for a grant, check it and the serial code timing through done.
   task automatic serve(input logic [1:0] drop, output int waited, output int gcyc);
      logic [3:0] code;
      exp_t       e;
      bit         seen;
      int         id;
      waited = 0;
      gcyc   = 0;
      seen   = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (grant != 2'b00) begin
            seen = 1;
            break;
         end
         waited++;
      end
      if (!seen) begin
         chk("grant_timeout", 32'(grant), 32'd1);
         return;
      end
      gcyc = cyc;
      id   = predict(req);
      if (id < 0) begin
         chk("grant_no_req", 32'(grant), 32'd0);
         return;
      end
      chk("grant",    32'(grant),    32'(2'b01 << id));
      chk("lock_clr", 32'(lock_clr), 32'd1);
      chk("busy",     32'(busy),     32'd1);
      code = code_in[id*4 +: 4];
      e.id = id;
      e.ok = (code == SECRET);
      if (e.ok)               exp_fail = 0;
      else if (exp_fail < 3)  exp_fail++;
      e.fcnt = exp_fail;
      sb.push_back(e);
      exp_ptr = (id + 1) % 2;
      for (int i = 0; i < 2; i++) if (drop[i]) req[i] = 1'b0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("lock_x", 32'(lock_x), 32'(code[3-b]));
      end
      @(negedge clk);
      chk("check_x",    32'(lock_x), 32'd0);
      chk("check_done", 32'(done),   32'd0);
      @(negedge clk);
      chk("done_time",  32'(done),   32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},  32'(grant),      32'd0);
      chk({tag, "_clr"},    32'(lock_clr),   32'd0);
      chk({tag, "_x"},      32'(lock_x),     32'd0);
      chk({tag, "_busy"},   32'(busy),       32'd0);
      chk({tag, "_done"},   32'(done),       32'd0);
      chk({tag, "_pass"},   32'(pass),       32'd0);
      chk({tag, "_id"},     32'(done_id),    32'd0);
      chk({tag, "_lo"},     32'(locked_out), 32'd0);
      chk({tag, "_fcnt"},   32'(fail_cnt),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int gc;
      int n;
      int g;
      int t[4];
      bit seen;

      rst     = 1'b1;
      req     = 2'b00;
      code_in = 8'h00;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Single correct attempt by requester 0.
      code_in = {4'b0000, SECRET};
      req     = 2'b01;
      serve(2'b01, w, gc);
      chk("single_wait", 32'(w), 32'd0);
      @(negedge clk);
      chk("single_idle_busy", 32'(busy), 32'd0);

      // Wrong code from requester 1, then a correct attempt clears the count.
      req = 2'b10;
      serve(2'b10, w, gc);
      req = 2'b01;
      serve(2'b01, w, gc);

      // Asynchronous reset in the middle of SHIFT.
      req  = 2'b01;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (grant != 2'b00) begin
            seen = 1;
            break;
         end
      end
      chk("pre_rst_grant", 32'(grant), 32'd1);
      req = 2'b00;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1 chk_all_zero("async_rst");
      sb.delete();
      exp_ptr  = 0;
      exp_fail = 0;
      code_in  = {SECRET, SECRET};
      req      = 2'b11;
      @(negedge clk);
      rst = 1'b0;

      // Round robin with both requests held: 0,1,0,1 every 8 cycles.
      for (int k = 0; k < 4; k++) begin
         serve(2'b00, w, gc);
         t[k] = gc;
      end
      for (int k = 1; k < 4; k++) chk("rr_period", 32'(t[k] - t[k-1]), 32'd8);

      // Three failures in a row trigger the lockout.
      code_in = 8'h00;
      for (int k = 0; k < 3; k++) serve(2'b00, w, gc);
      code_in = {SECRET, SECRET};
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (locked_out) begin
            n++;
            chk("lo_grant", 32'(grant), 32'd0);
         end else begin
            break;
         end
      end
      exp_fail = 0;
      chk("lockout_len",   32'(n),        32'd16);
      chk("post_lo_fcnt",  32'(fail_cnt), 32'd0);
      chk("post_lo_busy",  32'(busy),     32'd0);
      serve(2'b11, w, gc);
      chk("post_lo_wait",  32'(w),        32'd0);

      // Requester 1 pulses req while busy and must not be served.
      @(negedge clk);
      req = 2'b01;
      fork
         serve(2'b01, w, gc);
         begin
            repeat (3) @(negedge clk);
            req[1] = 1'b1;
            @(negedge clk);
            req[1] = 1'b0;
         end
      join
      g = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (grant != 2'b00) g++;
      end
      chk("wd_grants", 32'(g),         32'd0);
      chk("wd_busy",   32'(busy),      32'd0);
      chk("wd_sb",     32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
